// File: rtl/chacha_inv_rounds.sv
// Inverse ChaCha rounds: undoes ROUNDS forward half-rounds, one inverse half-round per cycle.
// Optional abort input is built only when CHACHA_INV_ABORT_EN is defined.
`timescale 1ns/1ps
module chacha_inv_rounds #(
  parameter int unsigned ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
`ifdef CHACHA_INV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned WW = 32;
  localparam int unsigned NW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NW-1:0][WW-1:0]  st_q, st_d;
  logic                   abort_c;

`ifdef CHACHA_INV_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WW - n));
  endfunction

  // Four inverse quarter-rounds in parallel; diag selects the diagonal grouping.
  function automatic logic [NW-1:0][WW-1:0] inv_half(input logic [NW-1:0][WW-1:0] s,
                                                      input logic diag);
    logic [NW-1:0][WW-1:0] r;
    logic [3:0]            ia, ib, ic, id;
    logic [WW-1:0]         a, b, c, d;
    r = s;
    for (int g = 0; g < 4; g++) begin
      ia = 4'(g);
      ib = diag ? 4'(4 + ((g + 1) % 4))  : 4'(4 + g);
      ic = diag ? 4'(8 + ((g + 2) % 4))  : 4'(8 + g);
      id = diag ? 4'(12 + ((g + 3) % 4)) : 4'(12 + g);
      a = s[ia];
      b = s[ib];
      c = s[ic];
      d = s[id];
      b = rotr(b, 7) ^ c;
      c = c - d;
      d = rotr(d, 8) ^ a;
      a = a - b;
      b = rotr(b, 12) ^ c;
      c = c - d;
      d = rotr(d, 16) ^ a;
      a = a - b;
      r[ia] = a;
      r[ib] = b;
      r[ic] = c;
      r[id] = d;
    end
    return r;
  endfunction

  // Next-state logic; odd counter values undo a diagonal half-round.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_state;
          cnt_d   = CW'(ROUNDS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_c) begin
          state_d = IDLE;
        end else begin
          st_d = inv_half(st_q, cnt_q[0]);
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: begin
        if (abort_c || out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      st_q      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign out_state = st_q;

endmodule

// File: tb/tb_chacha_inv_rounds.sv
// Bench for chacha_inv_rounds: forward ChaCha model, round-trip scoreboard, handshake and reset checks.
`timescale 1ns/1ps
module tb_chacha_inv_rounds;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy, abort;
  logic [511:0] in_state, out_state;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2, abort2;
  logic [511:0] in_state2, out_state2;

  chacha_inv_rounds #(.ROUNDS(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
`ifdef CHACHA_INV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  chacha_inv_rounds #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_state(in_state2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_state(out_state2),
`ifdef CHACHA_INV_ABORT_EN
    .abort(abort2),
`endif
    .busy(busy2)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit prev_ov = 1'b0;
  logic [511:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  int grp [2][4][4] = '{'{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15}},
                        '{'{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Forward half-round k of ChaCha: even k = columns, odd k = diagonals.
  function automatic logic [511:0] fwd_half(input logic [511:0] sin, input int k);
    logic [15:0][31:0] s;
    logic [31:0] a, b, c, d;
    int p;
    s = sin;
    p = k % 2;
    for (int g = 0; g < 4; g++) begin
      a = s[4'(grp[p][g][0])]; b = s[4'(grp[p][g][1])];
      c = s[4'(grp[p][g][2])]; d = s[4'(grp[p][g][3])];
      a += b; d ^= a; d = rl(d, 16);
      c += d; b ^= c; b = rl(b, 12);
      a += b; d ^= a; d = rl(d, 8);
      c += d; b ^= c; b = rl(b, 7);
      s[4'(grp[p][g][0])] = a; s[4'(grp[p][g][1])] = b;
      s[4'(grp[p][g][2])] = c; s[4'(grp[p][g][3])] = d;
    end
    return s;
  endfunction

  function automatic logic [511:0] inv_half_m(input logic [511:0] sin, input int k);
    logic [15:0][31:0] s;
    logic [31:0] a, b, c, d;
    int p;
    s = sin;
    p = k % 2;
    for (int g = 0; g < 4; g++) begin
      a = s[4'(grp[p][g][0])]; b = s[4'(grp[p][g][1])];
      c = s[4'(grp[p][g][2])]; d = s[4'(grp[p][g][3])];
      b = rr(b, 7) ^ c; c = c - d; d = rr(d, 8) ^ a; a = a - b;
      b = rr(b, 12) ^ c; c = c - d; d = rr(d, 16) ^ a; a = a - b;
      s[4'(grp[p][g][0])] = a; s[4'(grp[p][g][1])] = b;
      s[4'(grp[p][g][2])] = c; s[4'(grp[p][g][3])] = d;
    end
    return s;
  endfunction

  function automatic logic [511:0] fwd_n(input logic [511:0] s, input int n);
    logic [511:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = fwd_half(r, k);
    return r;
  endfunction

  function automatic logic [511:0] inv_n(input logic [511:0] s, input int n);
    logic [511:0] r;
    r = s;
    for (int k = n - 1; k >= 0; k--) r = inv_half_m(r, k);
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [15:0][31:0] r;
    for (int w = 0; w < 16; w++) r[w] = $urandom();
    return r;
  endfunction

  // Per-cycle compare of the ROUNDS=20 instance against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("ready_vs_busy", in_ready, !busy);
      chk1("ready_valid_exclusive", in_ready & out_valid, 1'b0);
      if (out_valid) begin
        if (!prev_ov) chki("latency", cyc - acc_cyc, 20);
        if (expq.size() == 0) begin
          chk1("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("out_state", out_state, expq[0]);
          if (out_ready && !abort) void'(expq.pop_front());
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [511:0] s, input logic [511:0] e);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_state = s;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk1("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    expq.push_back(e);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_state = rnd512();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(expq.size() == 0 && in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chki("drain_timeout", n < 200 ? 1 : 0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("wait_out_valid", out_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][31:0] s0;
    logic [15:0][31:0] f;
    logic [511:0] o, held, e2;
    int n;

    rst = 1'b1; abort = 1'b0; abort2 = 1'b0;
    in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_state2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_state", out_state, '0);
    chk("rst_out_state2", out_state2, '0);
    rst = 1'b0;

    // Model pinned to hand-computed column quarter-round values.
    s0 = '0;
    s0[0] = 32'h11111111; s0[4] = 32'h01020304; s0[8] = 32'h9b8d6f43; s0[12] = 32'h01234567;
    f = fwd_half(s0, 0);
    chk("model_w0", 512'(f[0]), 512'(32'hea2a92f4));
    chk("model_w4", 512'(f[4]), 512'(32'hcb1cf8ce));
    chk("model_w8", 512'(f[8]), 512'(32'h4581472e));
    chk("model_w12", 512'(f[12]), 512'(32'h5881c4bb));
    chk("model_inverse", inv_half_m(f, 0), s0);

    // All-zero state stays zero.
    send('0, '0);
    wait_idle();

    // ROUNDS=2 instance: diagonal inverse then column inverse.
    e2 = inv_n(f, 2);
    @(posedge clk); #1;
    in_valid2 = 1'b1; in_state2 = f;
    chk1("r2_in_ready", in_ready2, 1'b1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chki("r2_latency", cyc - acc_cyc, 2);
    chk("r2_out_state", out_state2, e2);
    @(posedge clk); #1;
    chk1("r2_back_idle", in_ready2, 1'b1);

    // Random round trips.
    for (int i = 0; i < 1000; i++) begin
      o = rnd512();
      send(fwd_n(o, 20), o);
    end
    wait_idle();

    // Back-pressure for 7 cycles in DONE, with in_valid ignored.
    out_ready = 1'b0;
    o = rnd512();
    send(fwd_n(o, 20), o);
    wait_valid();
    held = out_state;
    in_valid = 1'b1;
    in_state = rnd512();
    for (int k = 0; k < 7; k++) begin
      chk("bp_stable", out_state, held);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("bp_released_valid", out_valid, 1'b0);
    chk1("bp_released_ready", in_ready, 1'b1);
    chk("bp_retained", out_state, o);

    // Reset pulse in RUN cycle 5 discards the job.
    o = rnd512();
    send(fwd_n(o, 20), o);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_state", out_state, '0);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    o = rnd512();
    send(fwd_n(o, 20), o);
    wait_idle();

`ifdef CHACHA_INV_ABORT_EN
    // Abort in RUN cycle 3: back to IDLE, no output.
    o = rnd512();
    send(fwd_n(o, 20), o);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    expq.delete();
    chk1("abort_run_in_ready", in_ready, 1'b1);
    chk1("abort_run_out_valid", out_valid, 1'b0);
    chk1("abort_run_busy", busy, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    chk1("abort_run_no_valid", out_valid, 1'b0);

    // Abort together with out_ready in DONE.
    o = rnd512();
    send(fwd_n(o, 20), o);
    wait_valid();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    expq.delete();
    chk1("abort_done_out_valid", out_valid, 1'b0);
    chk1("abort_done_in_ready", in_ready, 1'b1);
    chk("abort_done_retained", out_state, o);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chacha_inv_rounds.md
CHACHA_INV_ROUNDS -- requirements
Module: chacha_inv_rounds

Interface
REQ-001 SHALL have parameter: ROUNDS, 20, number of half-rounds undone; legal values are even, 2..20.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  in_state is valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a state.
REQ-006 SHALL have port: in_state  input  512  state after ROUNDS forward ChaCha half-rounds; word i = bits [32i+31:32i].
REQ-007 SHALL have port: out_valid  output  1  out_state holds the recovered pre-round state.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts out_state.
REQ-009 SHALL have port: out_state  output  512  recovered state, same word order as in_state.
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port, only when CHACHA_INV_ABORT_EN is defined: abort  input  1  abandon the current job.

Function
REQ-012 SHALL implement three states: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-014 SHALL, in IDLE with in_valid high, register in_state, load round counter with ROUNDS-1, and enter RUN.
REQ-015 SHALL in RUN apply one inverse half-round per cycle, decrementing the counter.
REQ-016 SHALL apply half-rounds in reverse forward order: odd-indexed counter value = diagonal groups (0,5,10,15),(1,6,11,12),(2,7,8,13),(3,4,9,14); even = column groups (0,4,8,12),(1,5,9,13),(2,6,10,14),(3,7,11,15).
REQ-017 SHALL apply the four inverse quarter-rounds of a half-round in parallel, combinationally within the cycle.
REQ-018 SHALL compute each inverse quarter-round in this order, all mod 2^32, rotr = rotate right:
  b=rotr(b,7)^c; c=c-d; d=rotr(d,8)^a; a=a-b; b=rotr(b,12)^c; c=c-d; d=rotr(d,16)^a; a=a-b.
REQ-019 SHALL move from RUN to DONE after the half-round with counter 0; out_valid is first high exactly ROUNDS cycles after the accepting edge.
REQ-020 SHALL hold out_state stable in DONE until out_valid and out_ready are both high, then return to IDLE.
REQ-021 SHALL keep in_ready low in DONE even when out_ready is high in the same cycle; the next state is accepted at the earliest one cycle later.
REQ-022 SHALL ignore in_valid and in_state outside IDLE.
REQ-023 SHALL have out_state equal to the registered working state at all times.

Reset
REQ-024 SHALL on rst asynchronously enter IDLE, clear working state to zero, and clear the counter to zero.
REQ-025 SHALL drive these values during and after reset: in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-026 SHALL, if rst asserts mid-RUN or in DONE, discard the job with no partial output.

Configuration
REQ-027 SHALL implement the abort port and its behaviour only when macro CHACHA_INV_ABORT_EN is defined.
REQ-028 With the macro, abort high at a clock edge in RUN or DONE SHALL return the block to IDLE; out_valid SHALL be low the next cycle and working state is retained.
REQ-029 With the macro, abort SHALL be ignored in IDLE and SHALL take priority over out_ready.
REQ-030 Without the macro, the port SHALL be absent and only rst SHALL end a job.

Verification
REQ-031 SHALL check: all-zero in_state, ROUNDS=20 -> all-zero out_state, out_valid at cycle 20 after accept.
REQ-032 SHALL check: ROUNDS=2, only words 0,4,8,12 at their values after a single column half-round from 0x11111111/0x01020304/0x9b8d6f43/0x01234567, so that word0=0xea2a92f4, w4=0xcb1cf8ce, w8=0x4581472e, w12=0x5881c4bb; first the diagonal inverse runs, then the column inverse. Required: out_state matches the golden-model inverse of that input.
REQ-033 SHALL check round-trip: 1000 random 512-bit states, forward 20 half-rounds in the golden model -> DUT -> out_state equals the original state exactly.
REQ-034 SHALL check back-pressure: out_ready low for 7 cycles in DONE -> out_state stable, in_ready=0 throughout; accepted on cycle 8.
REQ-035 SHALL check reset: rst pulsed at RUN cycle 5 -> in_ready=1, out_valid=0, out_state=0 immediately; the next job completes normally.
REQ-036 SHALL check, with CHACHA_INV_ABORT_EN defined: abort at RUN cycle 3 -> IDLE next cycle, no out_valid; abort together with out_ready in DONE -> no handshake is counted.
